quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Front-end stage for the 8-bit up/down counter.
- Takes two asynchronous quadrature inputs (A/B) from an encoder or switch pair, then synchronises, glitch-filters and decodes them.
- Produces a one-cycle step pulse plus a direction level, which drive the counter's count-enable and up_down.
- Flags illegal transitions where both channels change at once.

Parameters:
FILT_LEN, 3, consecutive clk samples a synchronised input must hold a new value before the filtered value updates (legal 1..15).
SETTLE, FILT_LEN+2, cycles spent in INIT after reset before decoding starts.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
a_in  input  1  quadrature channel A, asynchronous
b_in  input  1  quadrature channel B, asynchronous
step  output  1  one-cycle pulse per legal quadrature transition
dir  output  1  direction of last legal step: 1 up, 0 down
err  output  1  one-cycle pulse when both filtered channels change in the same cycle
busy  output  1  high while in INIT (decoder not yet tracking)

Behaviour:
- Reset (rst high at a clk edge):
  - All flops cleared; step=0, err=0, dir=1, busy=1.
  - Filter counters=0, filtered A/B=0, prev state=00, FSM enters INIT.
  - Reset mid-operation aborts any in-progress filter count; no step or err is emitted during or on the cycle after reset.
- Synchroniser: two flops per channel (s1, s2). Only s2 feeds the filter.
- Filter, per channel:
  - If s2 equals the filtered value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach FILT_LEN, the filtered value takes s2 and the counter clears.
  - Pulses shorter than FILT_LEN cycles at s2 are rejected.
  - The counter width holds FILT_LEN and does not wrap.
- FSM states:
  - INIT:
    - Filtered values load s2 directly each cycle (no filtering).
    - prev loads {filtA,filtB} each cycle.
    - step and err are held 0.
    - A settle counter runs SETTLE cycles, then the FSM goes to TRACK and busy goes 0.
  - TRACK:
    - Each cycle, compare cur={filtA,filtB} with prev, then prev<=cur.
    - Up sequence (AB): 00->10->11->01->00. Any such transition gives step=1 and dir=1 next cycle.
    - Down sequence: reverse of the up sequence. Gives step=1 and dir=0.
    - cur==prev: step=0, dir held.
    - Both bits differ: err=1, step=0, dir held.
  - TRACK persists until rst.
- Latency:
  - A clean level change first sampled by s1 at edge E0 produces step high during the cycle after edge E0+FILT_LEN+2.
  - With FILT_LEN=3 this is 5 clocks.
- Throughput: at most one step per FILT_LEN cycles per channel. Steps on alternating channels may be FILT_LEN cycles apart.
- Outputs step, err, dir and busy are all registered; there are no combinational paths from inputs.

Optional Feature:
- Macro QDEC_POS_EN.
- When defined:
  - Adds output port pos (output, 8 bits).
  - pos is an internal position counter: reset 0.
  - On each step, pos increments when dir=1 and decrements when dir=0, modulo 256 (255+1 -> 0, 0-1 -> 255).
  - pos updates on the same edge step is asserted, using that step's direction.
  - pos is unchanged on err.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset then inputs A=0,B=0 for 10 cycles -> busy=1 for exactly 5 cycles then 0; step=0, err=0, dir=1 throughout.
- After INIT, drive AB 00->10->11->01->00, each level held 8 cycles -> exactly 4 step pulses, each 1 cycle wide, each 5 cycles after its edge; dir=1. With QDEC_POS_EN, pos goes 0->4.
- Drive down sequence 00->01->11->10->00 from pos=2 -> 4 steps, dir=0. With QDEC_POS_EN, pos 2->1->0->255->254.
- Glitch: A pulses high for 2 cycles (FILT_LEN=3) while B=0 -> no step, no err, filtered A stays 0.
- Change A and B together 00->11 -> exactly one err pulse, step=0, dir unchanged, pos unchanged. A subsequent 11->01 gives a normal up step.
- Assert rst for 1 cycle while A's filter count is at 2 -> no step; busy=1 for 5 cycles. Filtered AB loads the current input level without err, even if the inputs are 11.

Source files
------------

// File: rtl/quad_step_decoder_if.sv
// Bus bundle for quad_step_decoder: raw quadrature inputs and decoded outputs.
// QDEC_POS_EN adds the 8-bit position output.
interface quad_step_decoder_if;
    logic       a_in;
    logic       b_in;
    logic       step;
    logic       dir;
    logic       err;
    logic       busy;
`ifdef QDEC_POS_EN
    logic [7:0] pos;

    modport master (output a_in, b_in, input step, dir, err, busy, pos);
    modport slave  (input a_in, b_in, output step, dir, err, busy, pos);
`else
    modport master (output a_in, b_in, input step, dir, err, busy);
    modport slave  (input a_in, b_in, output step, dir, err, busy);
`endif
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature front end: 2-flop sync, per-channel glitch filter, step/dir/err decode.
// Optional macro QDEC_POS_EN adds an 8-bit wrap-around position counter on bus.pos.
module quad_step_decoder #(
    parameter int FILT_LEN = 3,
    parameter int SETTLE   = FILT_LEN + 2
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave bus
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic {INIT, TRACK} state_t;

    state_t               state_q, state_d;
    logic [1:0]           s1_q, s1_d, s2_q, s2_d;
    logic [1:0]           filt_q, filt_d, prev_q, prev_d;
    logic [1:0][CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 step_q, step_d, err_q, err_d;
    logic                 dir_q, dir_d, busy_q, busy_d;
    logic [1:0]           dph;
`ifdef QDEC_POS_EN
    logic [7:0]           pos_q, pos_d;
`endif

    // Position of an {A,B} pair along the up sequence 00->10->11->01.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    always_comb begin
        s1_d     = {bus.a_in, bus.b_in};
        s2_d     = s1_q;
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        settle_d = settle_q;
        state_d  = state_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        dir_d    = dir_q;
        dph      = phase(filt_q) - phase(prev_q);
`ifdef QDEC_POS_EN
        pos_d    = pos_q;
`endif
        case (state_q)
            INIT: begin
                // Unfiltered load so TRACK starts with prev already equal to cur.
                filt_d   = s2_q;
                prev_d   = s2_q;
                cnt_d    = '0;
                settle_d = settle_q + SW'(1);
                if (settle_q == SW'(SETTLE - 1)) state_d = TRACK;
            end
            default: begin
                for (int i = 0; i < 2; i++) begin
                    if (s2_q[i] == filt_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] + CW'(1) == CW'(FILT_LEN)) begin
                        filt_d[i] = s2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                prev_d = filt_q;
                if (filt_q != prev_q) begin
                    if (filt_q == ~prev_q) begin
                        err_d = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        dir_d  = (dph == 2'd1);
                    end
                end
            end
        endcase
        busy_d = (state_d == INIT);
`ifdef QDEC_POS_EN
        if (step_d) pos_d = dir_d ? pos_q + 8'd1 : pos_q - 8'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b1;
`ifdef QDEC_POS_EN
            pos_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            step_q   <= step_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
`ifdef QDEC_POS_EN
            pos_q    <= pos_d;
`endif
        end
    end

    assign bus.step = step_q;
    assign bus.err  = err_q;
    assign bus.dir  = dir_q;
    assign bus.busy = busy_q;
`ifdef QDEC_POS_EN
    assign bus.pos  = pos_q;
`endif
endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a history-window reference model predicts
// step/err events into a queue, a negedge monitor pops and compares them.
module tb_quad_step_decoder;
    localparam int FILT_LEN = 3;
    localparam int SETTLE   = FILT_LEN + 2;
    localparam int MASK     = (1 << FILT_LEN) - 1;

    typedef struct packed {
        int       cyc;
        bit       is_err;
        bit       dir;
        bit [7:0] pos;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_step_decoder_if bus();
    quad_step_decoder #(.FILT_LEN(FILT_LEN), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_steps = 0;
    int n_errs  = 0;
    ev_t exp_q[$];

    // Reference model state.
    bit [1:0] m_s1 = 0, m_s2 = 0, m_filt = 0, m_prev = 0, s2_old, cur;
    bit       m_dir = 1'b1, m_track = 1'b0;
    bit [7:0] m_pos = 0;
    int       m_settle = 0;
    int       hv[2] = '{0, 0};
    int       hn[2] = '{0, 0};
    bit [1:0] up_next[4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    ev_t      e;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_prev = 0;
            m_dir = 1'b1; m_pos = 0; m_settle = 0; m_track = 1'b0;
            hv = '{0, 0}; hn = '{0, 0};
        end else begin
            s2_old = m_s2;
            m_s2   = m_s1;
            m_s1   = {bus.a_in, bus.b_in};
            if (!m_track) begin
                m_filt = s2_old;
                m_prev = s2_old;
                hv = '{0, 0}; hn = '{0, 0};
                m_settle++;
                if (m_settle == SETTLE) m_track = 1'b1;
            end else begin
                cur = m_filt;
                // A channel flips once its last FILT_LEN samples all disagree with it.
                for (int ch = 0; ch < 2; ch++) begin
                    hv[ch] = ((hv[ch] << 1) | int'(s2_old[ch])) & MASK;
                    hn[ch]++;
                    if (hn[ch] >= FILT_LEN && hv[ch] == (cur[ch] ? 0 : MASK)) begin
                        m_filt[ch] = ~cur[ch];
                        hv[ch] = 0;
                        hn[ch] = 0;
                    end
                end
                if (cur != m_prev) begin
                    e.cyc = cyc;
                    e.is_err = 1'b0;
                    if (cur == ~m_prev) begin
                        e.is_err = 1'b1;
                    end else if (cur == up_next[m_prev]) begin
                        m_dir = 1'b1;
                        m_pos = m_pos + 8'd1;
                    end else begin
                        m_dir = 1'b0;
                        m_pos = m_pos - 8'd1;
                    end
                    e.dir = m_dir;
                    e.pos = m_pos;
                    exp_q.push_back(e);
                end
                m_prev = cur;
            end
        end
    end

    always @(negedge clk) begin
        ev_t x;
        check("busy", int'(bus.busy), int'(!m_track));
        check("dir", int'(bus.dir), int'(m_dir));
        if (bus.step === 1'b1 || bus.err === 1'b1) begin
            if (bus.step === 1'b1) n_steps++;
            if (bus.err === 1'b1) n_errs++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got step=%0b err=%0b, expected none (cycle %0d)",
                         bus.step, bus.err, cyc);
            end else begin
                x = exp_q.pop_front();
                check("event_cycle", cyc, x.cyc);
                check("event_kind", int'({bus.step, bus.err}), int'({~x.is_err, x.is_err}));
                check("event_dir", int'(bus.dir), int'(x.dir));
`ifdef QDEC_POS_EN
                check("event_pos", int'(bus.pos), int'(x.pos));
`endif
            end
        end
    end

    task automatic hold(input bit a, input bit b, input int n);
        bus.a_in = a;
        bus.b_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic busy_len(input string nm);
        int nb = 0;
        repeat (10) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
        end
        check(nm, nb, SETTLE);
    endtask

    initial begin
        int s0, e0;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_len("busy_after_reset");

        s0 = n_steps;
        hold(1, 0, 8); hold(1, 1, 8); hold(0, 1, 8); hold(0, 0, 8);
        check("up_steps", n_steps - s0, 4);
        check("up_dir", int'(bus.dir), 1);

        s0 = n_steps;
        hold(0, 1, 8); hold(1, 1, 8); hold(1, 0, 8); hold(0, 0, 8);
        check("down_steps", n_steps - s0, 4);
        check("down_dir", int'(bus.dir), 0);

        s0 = n_steps; e0 = n_errs;
        hold(1, 0, 2); hold(0, 0, 10);
        check("glitch_steps", n_steps - s0, 0);
        check("glitch_errs", n_errs - e0, 0);

        s0 = n_steps; e0 = n_errs;
        hold(1, 1, 8);
        check("double_errs", n_errs - e0, 1);
        check("double_steps", n_steps - s0, 0);
        hold(0, 1, 8);
        check("after_err_step", n_steps - s0, 1);
        check("after_err_dir", int'(bus.dir), 1);

        s0 = n_steps; e0 = n_errs;
        hold(1, 1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy_len("busy_after_midreset");
        check("midreset_steps", n_steps - s0, 0);
        check("midreset_errs", n_errs - e0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        hold(bus.a_in, bus.b_in, 20);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
